// File: rtl/psram_dev_rsp.sv
// Octal DDR PSRAM device-side responder.
// Oversamples the controller's sck on clk_i, decodes command/address frames, and serves a
// byte-addressed array plus four mode registers. Read data is returned with a DQS strobe.
module psram_dev_rsp #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned RLAT   = 5,
  parameter int unsigned WLAT   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StLat, StRdata, StWdata, StMrw, StIgnore
  } state_e;

  typedef enum logic [1:0] {OpRd, OpWr, OpMrr, OpMrw} op_e;

  localparam logic [15:0] RdEdges = 16'(2 * RLAT);
  localparam logic [15:0] WrEdges = 16'(2 * WLAT);
  // Edge count after which DQS is driven low for the final sck cycle of read latency.
  localparam logic [15:0] RdPre   = 16'(2 * RLAT - 2);

  state_e            state_q;
  op_e               op_q;
  logic              sck_q;
  logic              ce_q;
  logic [15:0]       cnt_q;
  logic [MEM_AW-1:0] ptr_q;
  logic [7:0]        mr_q [4];
  logic [7:0]        mem_q [2**MEM_AW];

  logic [7:0]        io_out_q;
  logic              io_en_q;
  logic              dqs_out_q;
  logic              dqs_en_q;

  logic              sck_edge;
  logic              is_rd;
  logic [15:0]       lat_edges;
  logic [15:0]       cnt_inc;
  logic [7:0]        rd_byte;
  logic              mem_we;

  // Edge detect, read-side data mux and array write strobe.
  always_comb begin
    sck_edge  = psram_sck_i ^ sck_q;
    is_rd     = (op_q == OpRd) || (op_q == OpMrr);
    lat_edges = is_rd ? RdEdges : WrEdges;
    cnt_inc   = cnt_q + 16'd1;
    rd_byte   = (op_q == OpMrr) ? mr_q[ptr_q[1:0]] : mem_q[ptr_q];
    // ce high wins over a coincident edge; masked bytes still advance the pointer.
    mem_we    = !rst_i && !psram_ce_i && sck_edge && (state_q == StWdata) && !psram_dqs_in_i;
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ptr_q] <= psram_io_in_i;
    end
  end

  // Frame FSM with registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= OpRd;
      sck_q     <= 1'b0;
      ce_q      <= 1'b1;
      cnt_q     <= '0;
      ptr_q     <= '0;
      mr_q[0]   <= 8'h01;
      mr_q[1]   <= 8'h00;
      mr_q[2]   <= 8'h00;
      mr_q[3]   <= 8'h00;
      io_out_q  <= 8'h00;
      io_en_q   <= 1'b0;
      dqs_out_q <= 1'b0;
      dqs_en_q  <= 1'b0;
    end else begin
      sck_q <= psram_sck_i;
      ce_q  <= psram_ce_i;
      if (psram_ce_i) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        io_out_q  <= 8'h00;
        io_en_q   <= 1'b0;
        dqs_out_q <= 1'b0;
        dqs_en_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            // Only a fresh ce falling edge opens a frame.
            if (ce_q) begin
              state_q <= StCmd;
              cnt_q   <= '0;
            end
          end
          StCmd: begin
            if (sck_edge) begin
              if (cnt_q == 16'd0) begin
                cnt_q <= cnt_inc;
                case (psram_io_in_i)
                  8'h00:   op_q <= OpRd;
                  8'h80:   op_q <= OpWr;
                  8'h40:   op_q <= OpMrr;
                  8'hC0:   op_q <= OpMrw;
                  default: state_q <= StIgnore;
                endcase
              end else begin
                state_q <= StAddr;
                cnt_q   <= '0;
              end
            end
          end
          StAddr: begin
            if (sck_edge) begin
              // Shift address bytes in; only the low MEM_AW bits are kept.
              ptr_q <= MEM_AW'({ptr_q, psram_io_in_i});
              if (cnt_q == 16'd3) begin
                cnt_q   <= '0;
                state_q <= (op_q == OpMrw) ? StMrw : StLat;
                if (is_rd && (RdPre == 16'd0)) begin
                  dqs_en_q  <= 1'b1;
                  dqs_out_q <= 1'b0;
                end
              end else begin
                cnt_q <= cnt_inc;
              end
            end
          end
          StLat: begin
            if (sck_edge) begin
              if (cnt_inc == lat_edges) begin
                cnt_q <= '0;
                if (is_rd) begin
                  // Present the first byte, aligned to the coming rising edge.
                  state_q   <= StRdata;
                  io_out_q  <= rd_byte;
                  io_en_q   <= 1'b1;
                  dqs_out_q <= 1'b1;
                  dqs_en_q  <= 1'b1;
                  if (op_q == OpRd) begin
                    ptr_q <= ptr_q + MEM_AW'(1);
                  end
                end else begin
                  state_q <= StWdata;
                end
              end else begin
                cnt_q <= cnt_inc;
                if (is_rd && (cnt_inc == RdPre)) begin
                  dqs_en_q  <= 1'b1;
                  dqs_out_q <= 1'b0;
                end
              end
            end
          end
          StRdata: begin
            if (sck_edge) begin
              io_out_q  <= rd_byte;
              dqs_out_q <= ~dqs_out_q;
              if (op_q == OpRd) begin
                ptr_q <= ptr_q + MEM_AW'(1);
              end
            end
          end
          StWdata: begin
            if (sck_edge) begin
              ptr_q <= ptr_q + MEM_AW'(1);
            end
          end
          StMrw: begin
            if (sck_edge) begin
              mr_q[ptr_q[1:0]] <= psram_io_in_i;
              state_q          <= StIgnore;
            end
          end
          StIgnore: begin
            io_en_q  <= 1'b0;
            dqs_en_q <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Reset forces the bus quiet in the same cycle it is asserted.
  always_comb begin
    psram_io_out_o  = rst_i ? 8'h00 : io_out_q;
    psram_io_en_o   = {8{io_en_q & ~rst_i}};
    psram_dqs_out_o = dqs_out_q & ~rst_i;
    psram_dqs_en_o  = dqs_en_q & ~rst_i;
  end

endmodule

// File: doc/psram_dev_rsp.md
Name: psram_dev_rsp

Overview:
- Synthesizable octal DDR PSRAM device-side responder: the memory end of the bus driven by the PSRAM controller.
- Runs on the fast system clock and oversamples psram_sck_i. It decodes command/address frames, holds a byte-addressed memory array and four mode registers, and answers reads with data plus a DQS strobe.
- Used as an open replacement for the vendor model in controller benches and FPGA loopback.

Parameters:
MEM_AW, 12, byte address width of internal array (2**MEM_AW bytes)
RLAT, 5, read latency in sck cycles between last address edge and first read data edge
WLAT, 5, write latency in sck cycles between last address edge and first write data edge

Ports:
clk_i  in  1  system clock; sck half-period must be at least 2 clk_i cycles
rst_i  in  1  synchronous reset, active-high
psram_sck_i  in  1  bus clock from controller, treated as data
psram_ce_i  in  1  chip enable, active-low
psram_io_in_i  in  8  DQ from controller
psram_io_out_o  out  8  DQ to controller
psram_io_en_o  out  8  DQ drive enable, 1 = drive, all bits equal
psram_dqs_in_i  in  1  write data mask from controller, 1 = mask byte
psram_dqs_out_o  out  1  read strobe
psram_dqs_en_o  out  1  DQS drive enable, 1 = drive

Behaviour:
- Reset: all outputs 0; state IDLE; MR0=8'h01, MR1=8'h00, MR2=8'h00, MR3=8'h00. Array contents are not cleared. Reset mid-frame aborts to IDLE and the same cycle's outputs are 0.
- Edge detect: sck_q registers psram_sck_i each clk_i.
  - rise = sck & ~sck_q; fall = ~sck & sck_q; edge = rise | fall.
  - io/dqs inputs are sampled in the clk_i cycle where edge is 1.
- Frame start: ce falling while IDLE enters CMD. ce high in any state returns to IDLE next cycle, clears io_en/dqs_en, and discards any partial address. Write bytes already committed stay.
- CMD (2 edges): the rise byte is the opcode; the fall byte is ignored.
  - 8'h00 sync read.
  - 8'h80 sync write.
  - 8'h40 mode-reg read.
  - 8'hC0 mode-reg write.
  - Any other opcode goes to IGNORE, which holds outputs 0 until ce high.
- ADDR (4 edges): bytes A[31:24], A[23:16], A[15:8], A[7:0], in that order. The internal pointer is A[MEM_AW-1:0]; upper bits are ignored.
- LAT: counts 2*RLAT edges for reads, 2*WLAT edges for sync write.
  - For reads, dqs_en=1 and dqs_out=0 during the final sck cycle of latency.
  - Mode-reg write skips LAT.
- RDATA: one byte per edge.
  - The byte for the next edge is presented on io_out the cycle after the current edge is detected. The first byte is presented the cycle after the last LAT edge.
  - dqs_out toggles with each byte: 1 for bytes aligned to rise, 0 for fall. io_en=8'hFF and dqs_en=1 while in RDATA.
  - The pointer increments per byte and wraps from 2**MEM_AW-1 to 0.
  - Mode-reg read returns MR[A[1:0]] on every byte with no increment.
- WDATA: one byte per edge.
  - If dqs_in=0 at the edge, mem[ptr] is written that cycle; if 1, the write is suppressed. The pointer increments either way, with the same wrap rule.
  - io_en and dqs_en stay 0.
- MRW: the first edge after address writes MR[A[1:0]] with io_in. Following edges go to IGNORE.
- Bursts are unbounded until ce high.
- Simultaneous ce rise and edge in the same clk_i cycle: ce wins; no write, no pointer update.
- ce low with no sck edges: all state is held.

Test Plan:
- Sync write 0x80, addr 0x00000010, WLAT=5, data 11,22,33,44 with all dqs_in=0, then sync read 0x00 same addr -> after 10 latency edges, io_out gives 11,22,33,44; dqs_out 1,0,1,0; dqs_en high only during the final latency cycle and data.
- Write 0xAA,0xBB,0xCC at 0x20 with dqs_in=0,1,0 -> read back returns AA, old value, CC.
- Wrap: with MEM_AW=12, write 2 bytes at 0xFFF -> mem[0xFFF]=first, mem[0x000]=second; read from 0xFFF returns both in order.
- Mode regs: MRW 0xC0 addr 2 data 0x5A; MRR 0x40 addr 2 -> 0x5A repeated; MRR addr 0 after reset -> 0x01.
- Abort: ce high after 2 of 4 write data bytes -> first 2 bytes stored, remaining addresses unchanged, io_en/dqs_en 0 the next cycle.
- Illegal opcode 0x33, then 8 edges with io_in=0xFF -> no memory change, outputs 0. Reset asserted mid-read -> outputs 0 and MR0=0x01, and prior array data is still readable afterward.
